// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 32;

    localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [IMEM_DATA_W-1:0] data;
        logic                   err;
    } imem_rsp_t;

    // Word-index width for a memory of depth_words 32-bit words.
    function automatic int word_idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               din_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; a stale slot is never visible because empty masks it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed latency,
// buffered against decode stalls and discarded on flush, with a program-load write port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_err,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int IDX_W = word_idx_w(DEPTH_WORDS);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int RSP_W = $bits(imem_rsp_t);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             consume;
    logic             req_err;
    logic             wr_ok;
    logic [IDX_W-1:0] req_idx;
    imem_rsp_t        lookup;
    imem_rsp_t        push_rsp;
    logic             push_vld;
    logic [CNT_W-1:0] pipe_cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] outstanding;
    logic [RSP_W-1:0] fifo_dout;
    imem_rsp_t        head;
    logic             fifo_full;
    logic             fifo_empty;

    assign outstanding = pipe_cnt + fifo_cnt;
    assign req_ready   = !flush && !fifo_full && (outstanding < CNT_W'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;
    assign consume     = rsp_valid && rsp_ready;

    // Out of range means any address bit above the word index is set.
    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
    assign req_idx = req_addr[IDX_W+1:2];
    assign wr_ok   = wr_en && (wr_addr[1:0] == 2'b00) && ((wr_addr >> (IDX_W + 2)) == '0);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr[IDX_W+1:2]] <= wr_data;
        end
    end

    // Combinational read sees the pre-edge array, so a same-edge write returns old data.
    always_comb begin
        lookup      = '0;
        lookup.addr = req_addr;
        lookup.err  = req_err;
        lookup.data = req_err ? NOP_INSTR : mem_q[req_idx];
    end

    if (LATENCY == 1) begin : g_lat1
        assign push_rsp = lookup;
        assign push_vld = accept;
        assign pipe_cnt = '0;
    end else begin : g_pipe
        imem_rsp_t          pipe_q [LATENCY-1];
        logic [LATENCY-2:0] vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pipe_q[0] <= lookup;
            for (int k = 1; k < LATENCY - 1; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end

        always_comb begin
            pipe_cnt = '0;
            for (int k = 0; k < LATENCY - 1; k++) begin
                pipe_cnt = pipe_cnt + CNT_W'(vld_q[k]);
            end
        end

        assign push_rsp = pipe_q[LATENCY-2];
        assign push_vld = vld_q[LATENCY-2];
    end

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (push_vld),
        .din_i   (push_rsp),
        .pop_i   (consume),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs are forced to zero while empty so reset and idle look identical.
    assign head      = imem_rsp_t'(fifo_dout);
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : head.data;
    assign rsp_addr  = fifo_empty ? '0 : head.addr;
    assign rsp_err   = fifo_empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with hand-computed expected responses.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
        check_val({tag, "_vld"},  rsp_valid, 1);
        check_val({tag, "_addr"}, rsp_addr, a);
        check_val({tag, "_data"}, rsp_data, d);
        check_val({tag, "_err"},  rsp_err, e);
    endtask

    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    logic [31:0] img   [3];
    int          acc;
    logic        stale;

    initial begin
        img[0] = 32'h0000_0093;
        img[1] = 32'h0010_0113;
        img[2] = 32'h0020_0193;

        step();
        step();
        rst_n = 1'b1;
        #1;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data",  rsp_data, 0);
        check_val("rst_rsp_addr",  rsp_addr, 0);
        check_val("rst_rsp_err",   rsp_err, 0);

        load_word(32'h0, img[0]);
        load_word(32'h4, img[1]);
        load_word(32'h8, img[2]);
        load_word(32'hFFC, 32'h0000_0073);

        // Back-to-back fetches with the consumer always ready
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        check_val("b2b_lat_not_yet", rsp_valid, 0);
        req_addr = 32'h4;
        step();
        check_rsp("b2b0", 32'h0, img[0], 1'b0);
        req_addr = 32'h8;
        step();
        check_rsp("b2b1", 32'h4, img[1], 1'b0);
        req_valid = 1'b0;
        step();
        check_rsp("b2b2", 32'h8, img[2], 1'b0);
        step();
        check_val("b2b_drained", rsp_valid, 0);

        // Stalled consumer: fill to RSP_DEPTH, then drain in order
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'(4 * (acc % 3));
            if (req_ready) begin
                exp_a[acc] = req_addr;
                exp_d[acc] = img[acc % 3];
                acc++;
            end
            step();
        end
        req_valid = 1'b0;
        check_val("fill_accepts", acc, 4);
        check_val("fill_ready_low", req_ready, 0);
        check_val("fill_hold_addr", rsp_addr, 32'h0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_rsp($sformatf("drain%0d", i), exp_a[i], exp_d[i], 1'b0);
            step();
            if (i == 0) check_val("drain_ready_back", req_ready, 1);
        end
        check_val("drain_empty", rsp_valid, 0);

        // Flush with three requests outstanding
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_addr = 32'h0;
        step();
        flush    = 1'b1;
        req_addr = 32'h8;
        #1;
        check_val("flush_ready_low", req_ready, 0);
        step();
        flush     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_val("flush_vld_cleared", rsp_valid, 0);
        check_val("flush_ready_back", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        check_rsp("post_flush", 32'h8, img[2], 1'b0);
        step();
        check_val("post_flush_nothing_more", rsp_valid, 0);

        // Misaligned, out-of-range and last-word fetches
        req_valid = 1'b1;
        req_addr  = 32'h2;
        step();
        req_addr = 32'h1000;
        step();
        check_rsp("err_misalign", 32'h2, 32'h0000_0013, 1'b1);
        req_addr = 32'hFFC;
        step();
        check_rsp("err_range", 32'h1000, 32'h0000_0013, 1'b1);
        req_valid = 1'b0;
        step();
        check_rsp("last_word", 32'hFFC, 32'h0000_0073, 1'b0);
        step();

        // Same-edge write and read of one word
        req_valid = 1'b1;
        req_addr  = 32'h4;
        wr_en     = 1'b1;
        wr_addr   = 32'h4;
        wr_data   = 32'hCAFE_BABE;
        step();
        wr_en = 1'b0;
        step();
        req_valid = 1'b0;
        check_rsp("coll_old", 32'h4, img[1], 1'b0);
        step();
        check_rsp("coll_new", 32'h4, 32'hCAFE_BABE, 1'b0);
        step();

        // Asynchronous reset mid-cycle with two responses pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        step();
        check_rsp("pre_rst", 32'h0, img[0], 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_rsp_valid", rsp_valid, 0);
        check_val("arst_rsp_data",  rsp_data, 0);
        check_val("arst_rsp_addr",  rsp_addr, 0);
        #3;
        rst_n = 1'b1;
        step();
        check_val("arst_req_ready", req_ready, 1);
        rsp_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stale = stale | rsp_valid;
            step();
        end
        check_val("arst_no_stale", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by program_counter.
- Accepts fetch requests (PC address) over a valid/ready handshake and returns the 32-bit instruction in order after a fixed pipeline latency.
- Buffers responses when decode stalls, and discards everything in flight when a jump/branch flush is signalled.
- Has a side write port so benches and the boot loader can load the program image.

Parameters:
- ADDR_WIDTH, 32: byte-address width, same as the PC.
- DATA_WIDTH, 32: instruction width.
- DEPTH_WORDS, 1024: memory size in 32-bit words; must be a power of 2.
- LATENCY, 2: read latency in cycles, legal range 1..4.
- RSP_DEPTH, 4: response FIFO depth; must be >= LATENCY.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  fetch byte address (PC).
- flush  in  1  kill all in-flight and queued responses.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_WIDTH  instruction word.
- rsp_addr  out  ADDR_WIDTH  address the response belongs to.
- rsp_err  out  1  misaligned or out-of-range fetch.
- wr_en  in  1  program-load write enable.
- wr_addr  in  ADDR_WIDTH  program-load byte address; word aligned.
- wr_data  in  DATA_WIDTH  program-load data.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=1 in the first cycle after release; rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0.
  - Outstanding count=0, FIFO empty, pipeline valids cleared.
  - Memory contents are not reset.
  - Reset mid-operation drops all requests; no response for them ever appears.
- Handshakes:
  - A request is accepted on a rising edge when req_valid && req_ready.
  - A response is consumed when rsp_valid && rsp_ready.
  - rsp_data/rsp_addr/rsp_err hold stable while rsp_valid && !rsp_ready.
- Flow control:
  - outstanding = in-pipeline entries + FIFO entries; it increments on accept and decrements on consume, and both can happen on the same edge.
  - req_ready = !flush && (outstanding < RSP_DEPTH). It must not depend on req_valid.
- Latency:
  - A request accepted at edge N produces rsp_valid=1 in the cycle after edge N+LATENCY-1 if nothing older is queued.
  - Back-to-back accepts with rsp_ready=1 give one response per cycle.
- Ordering: responses are strictly in acceptance order.
- Read data:
  - The word index is req_addr[log2(DEPTH_WORDS)+1:2].
  - rsp_err=1 if req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS. In that case rsp_data=NOP_INSTR (32'h0000_0013) and no array read occurs.
- Write/read collision: a write and an accepted read to the same word on the same edge returns the OLD data; the write takes effect for later reads.
- Flush:
  - On the edge where flush=1, all pipeline valids and FIFO entries are cleared and outstanding=0. rsp_valid=0 in the following cycle.
  - A response handshaken in the flush cycle still counts as consumed.
  - No request is accepted in the flush cycle.
  - Writes proceed normally during flush.
- Address wrap: the PC wrap 32'hFFFF_FFFC -> 0 needs no special handling; out-of-range addresses are flagged as errors.

Decomposition:
- imem_pkg holds:
  - NOP_INSTR constant.
  - The imem_rsp_t struct {addr, data, err}.
  - The localparam rule for the word-index width.
- One sub-module: sync_fifo, parameterised by width and depth, storing imem_rsp_t. It provides count, full and empty, and has a synchronous clear input driven by flush.

Test Plan:
- Load words 0x00000093, 0x00100113, 0x00200193 at byte addresses 0x0, 0x4, 0x8. Request 0x0, 0x4, 0x8 back-to-back with rsp_ready=1. -> Three responses in consecutive cycles with the same data and addresses; the first appears 2 cycles after the first accept; rsp_err=0.
- Hold rsp_ready=0 and keep req_valid=1. -> Exactly RSP_DEPTH=4 requests accepted, then req_ready=0. Raising rsp_ready drains all 4 in order, and req_ready returns to 1 on the same edge as the first consume.
- With 3 requests outstanding, pulse flush for one cycle while req_valid=1. -> req_ready=0 in that cycle; rsp_valid=0 afterwards. A new request to 0x8 returns 0x00200193 with nothing stale in front of it.
- Request 0x2 and 0x1000 (DEPTH_WORDS=1024). -> Both responses have rsp_err=1, rsp_data=32'h0000_0013 and rsp_addr echoed.
- Write 0xCAFEBABE to 0x4 on the same edge as accepting a read of 0x4. -> The response returns the old 0x00100113; the next read of 0x4 returns 0xCAFEBABE.
- Assert rst_n=0 asynchronously, mid-cycle, with 2 responses pending. -> rsp_valid=0 and rsp_data=0 immediately; req_ready=1 after release; no stale response ever appears.
